ma_job_sequencer: RTL and testbench

Control sequencer for the 3x3 matrix accelerator wrapper. The block accepts a job command, steps the accelerator crossbar `AddressSelect` through a run of consecutive addresses, and fires `mStart` once per address. It waits for each `finalReady` (bounded by a timeout) and returns each `finalAccumulate` on a valid/ready result stream. It sits between the host-side command logic and the accelerator control pins; the operand buses are not touched.

---
 rtl/ma_job_sequencer_if.sv | 42 ++++
 rtl/ma_job_sequencer.sv | 151 +++++++++++++++
 tb/tb_ma_job_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ma_job_sequencer_if.sv
// Handshake bundle between the job sequencer, its host-side command/result
// logic and the 3x3 matrix accelerator control pins.
interface ma_job_sequencer_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = $clog2(KERNEL_SIZE**4)
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_WIDTH-1:0]     cmd_base;
  logic [ADDR_WIDTH-1:0]     cmd_count;
  logic                      cmd_direct;
  logic                      abort;
  logic [ADDR_WIDTH-1:0]     ma_addr;
  logic [KERNEL_SIZE**2-1:0] ma_mstart;
  logic                      ma_direct;
  logic [31:0]               ma_acc;
  logic                      ma_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [31:0]               res_data;
  logic [ADDR_WIDTH-1:0]     res_idx;
  logic                      res_last;
  logic                      busy;
  logic                      done;
  logic                      timeout_err;

  modport master (
    input  cmd_valid, cmd_base, cmd_count, cmd_direct, abort,
    input  ma_acc, ma_ready, res_ready,
    output cmd_ready, ma_addr, ma_mstart, ma_direct,
    output res_valid, res_data, res_idx, res_last,
    output busy, done, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_count, cmd_direct, abort,
    output ma_acc, ma_ready, res_ready,
    input  cmd_ready, ma_addr, ma_mstart, ma_direct,
    input  res_valid, res_data, res_idx, res_last,
    input  busy, done, timeout_err
  );
endinterface

// File: rtl/ma_job_sequencer.sv
// Job sequencer for the 3x3 matrix accelerator: walks AddressSelect over a run
// of addresses, pulses mStart per pass and streams each finalAccumulate out.
module ma_job_sequencer #(
  parameter int KERNEL_SIZE    = 3,
  parameter int ADDR_WIDTH     = $clog2(KERNEL_SIZE**4),
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               Clk,
  input logic               Rst,
  ma_job_sequencer_if.master bus
);

  localparam int LANES = KERNEL_SIZE**2;
  localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_OUT, S_DONE
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q, count_q, idx_q;
  logic [TW-1:0]         timer_q;
  logic                  cmd_ready_q, busy_q, done_q, timeout_err_q;
  logic [ADDR_WIDTH-1:0] ma_addr_q;
  logic [LANES-1:0]      ma_mstart_q;
  logic                  ma_direct_q;
  logic                  res_valid_q, res_last_q;
  logic [31:0]           res_data_q;
  logic [ADDR_WIDTH-1:0] res_idx_q;

  logic [ADDR_WIDTH-1:0] next_idx_d, next_addr_d;

  // Address wraps modulo 2^ADDR_WIDTH by truncation.
  assign next_idx_d  = idx_q + ADDR_WIDTH'(1);
  assign next_addr_d = base_q + next_idx_d;

  // NOTE: every register here is state, so all updates are non-blocking; the
  // two pulse outputs get a default of 0 at the top of the clocked branch.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      ma_addr_q     <= '0;
      ma_mstart_q   <= '0;
      ma_direct_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
    end else begin
      done_q      <= 1'b0;
      ma_mstart_q <= '0;
      if (bus.abort && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        res_valid_q <= 1'b0;
        cmd_ready_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
              base_q        <= bus.cmd_base;
              count_q       <= bus.cmd_count;
              ma_direct_q   <= bus.cmd_direct;
              idx_q         <= '0;
              timeout_err_q <= 1'b0;
              cmd_ready_q   <= 1'b0;
              busy_q        <= 1'b1;
              if (bus.cmd_count == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_SETUP;
                ma_addr_q <= bus.cmd_base;
              end
            end else begin
              cmd_ready_q <= 1'b1;
            end
          end
          S_SETUP: begin
            state_q     <= S_START;
            ma_mstart_q <= '1;
          end
          S_START: begin
            state_q <= S_WAIT;
            timer_q <= '0;
          end
          S_WAIT: begin
            // A late ready on the final allowed cycle still wins over timeout.
            if (bus.ma_ready) begin
              state_q     <= S_OUT;
              res_valid_q <= 1'b1;
              res_data_q  <= bus.ma_acc;
              res_idx_q   <= idx_q;
              res_last_q  <= (idx_q == count_q - ADDR_WIDTH'(1));
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 2)) begin
              state_q       <= S_DONE;
              timeout_err_q <= 1'b1;
              done_q        <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_OUT: begin
            if (bus.res_ready) begin
              res_valid_q <= 1'b0;
              if (res_last_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_SETUP;
                idx_q     <= next_idx_d;
                ma_addr_q <= next_addr_d;
              end
            end
          end
          S_DONE: begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          default: begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.ma_addr     = ma_addr_q;
  assign bus.ma_mstart   = ma_mstart_q;
  assign bus.ma_direct   = ma_direct_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_idx     = res_idx_q;
  assign bus.res_last    = res_last_q;

endmodule

// File: tb/tb_ma_job_sequencer.sv
// Scoreboard bench for ma_job_sequencer: a small accelerator model answers
// each mStart and queues the expected result; a monitor pops and compares.
module tb_ma_job_sequencer;

  localparam int KS = 3;
  localparam int AW = 7;
  localparam int TO = 8;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;

  ma_job_sequencer_if #(.KERNEL_SIZE(KS), .ADDR_WIDTH(AW)) bus ();

  ma_job_sequencer #(.KERNEL_SIZE(KS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t sb[$];

  logic [AW-1:0] exp_base;
  int            exp_count;
  logic          exp_direct;
  int            job_pass, acc_pass, acc_lat, cd;
  logic [31:0]   acc_seed;
  int            mstart_cnt = 0, res_cnt = 0, rv_cnt = 0, done_cnt = 0;
  int            mstart_cyc, done_cyc, acc_cyc;
  logic          prev_mstart = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Accelerator model: raises finalReady acc_lat cycles after each mStart.
  always @(posedge Clk) begin
    #1;
    if (Rst) begin
      cd           = 0;
      bus.ma_ready = 1'b0;
      bus.ma_acc   = '0;
    end else begin
      bus.ma_ready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.ma_acc   = acc_seed + 32'(100 * (acc_pass + 1));
          bus.ma_ready = 1'b1;
          sb.push_back('{data: bus.ma_acc, idx: AW'(acc_pass),
                         last: (acc_pass == exp_count - 1)});
          acc_pass++;
        end
      end
      if (bus.ma_mstart != '0 && acc_lat > 0) cd = acc_lat;
    end
  end

  // Output monitor, sampling mid-cycle.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (bus.ma_mstart != '0) begin
        logic [AW-1:0] ea;
        ea = exp_base + AW'(job_pass);
        check("mstart_ones", 32'(bus.ma_mstart), 32'h1FF);
        check("mstart_width", 32'(prev_mstart), 32'd0);
        check("ma_addr", 32'(bus.ma_addr), 32'(ea));
        check("ma_direct", 32'(bus.ma_direct), 32'(exp_direct));
        job_pass++;
        mstart_cnt++;
        mstart_cyc = cyc;
      end
      prev_mstart = (bus.ma_mstart != '0);
      if (bus.res_valid) rv_cnt++;
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_data", bus.res_data, e.data);
          check("res_idx", 32'(bus.res_idx), 32'(e.idx));
          check("res_last", 32'(bus.res_last), 32'(e.last));
        end
        res_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] b, input logic [AW-1:0] c, input logic d);
    bit ok = 0;
    exp_base = b; exp_count = int'(c); exp_direct = d;
    job_pass = 0; acc_pass = 0;
    bus.cmd_base = b; bus.cmd_count = c; bus.cmd_direct = d;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (bus.cmd_ready) begin
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    if (!ok) check("cmd_accept", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int  d0 = done_cnt;
    bit  seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge Clk);
      #1;
      if (done_cnt != d0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_seen", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, r0, v0, d0;
    bit seen;
    Rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_count = '0; bus.cmd_direct = 1'b0;
    bus.abort = 1'b0; bus.res_ready = 1'b1;
    acc_lat = 1; acc_seed = 0; exp_base = '0; exp_count = 0; exp_direct = 1'b0;
    job_pass = 0; acc_pass = 0;

    // Reset values
    repeat (3) @(posedge Clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mstart", 32'(bus.ma_mstart), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    check("rst_addr", 32'(bus.ma_addr), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    check("cmd_ready_pre", 32'(bus.cmd_ready), 32'd0);
    @(posedge Clk);
    #1;
    check("cmd_ready_rise", 32'(bus.cmd_ready), 32'd1);

    // Basic job: base 5, three passes
    m0 = mstart_cnt; r0 = res_cnt;
    acc_seed = 0; acc_lat = 1;
    send_cmd(7'd5, 7'd3, 1'b1);
    check("basic_busy", 32'(bus.busy), 32'd1);
    check("basic_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    wait_done();
    check("basic_done_time", 32'(done_cyc - acc_cyc), 32'd12);
    check("basic_mstarts", 32'(mstart_cnt - m0), 32'd3);
    check("basic_results", 32'(res_cnt - r0), 32'd3);
    check("basic_idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("basic_idle_busy", 32'(bus.busy), 32'd0);

    // Wrap-around and backpressure on the first result
    m0 = mstart_cnt; r0 = res_cnt;
    acc_seed = 1000;
    bus.res_ready = 1'b0;
    send_cmd(7'd127, 7'd2, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      if (bus.res_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("bp_valid_seen", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("bp_valid", 32'(bus.res_valid), 32'd1);
      check("bp_data", bus.res_data, 32'd1100);
      check("bp_idx", 32'(bus.res_idx), 32'd0);
      check("bp_last", 32'(bus.res_last), 32'd0);
      check("bp_no_mstart", 32'(mstart_cnt - m0), 32'd1);
    end
    @(posedge Clk);
    #1;
    bus.res_ready = 1'b1;
    wait_done();
    check("wrap_mstarts", 32'(mstart_cnt - m0), 32'd2);
    check("wrap_results", 32'(res_cnt - r0), 32'd2);

    // Zero count
    m0 = mstart_cnt; v0 = rv_cnt;
    send_cmd(7'd9, 7'd0, 1'b1);
    wait_done();
    check("zero_done_time", 32'(done_cyc - acc_cyc), 32'd0);
    check("zero_mstarts", 32'(mstart_cnt - m0), 32'd0);
    check("zero_res_valid", 32'(rv_cnt - v0), 32'd0);

    // Timeout: accelerator never answers
    m0 = mstart_cnt; v0 = rv_cnt;
    acc_lat = 0;
    send_cmd(7'd10, 7'd2, 1'b0);
    wait_done();
    check("to_done_after_mstart", 32'(done_cyc - mstart_cyc), 32'(TO));
    check("to_flag", 32'(bus.timeout_err), 32'd1);
    check("to_mstarts", 32'(mstart_cnt - m0), 32'd1);
    check("to_res_valid", 32'(rv_cnt - v0), 32'd0);
    check("to_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    acc_lat = 1;
    send_cmd(7'd3, 7'd0, 1'b0);
    check("to_flag_cleared", 32'(bus.timeout_err), 32'd0);
    wait_done();

    // Abort in WAIT of pass 1 of 4
    m0 = mstart_cnt; r0 = res_cnt; d0 = done_cnt;
    acc_lat = 3; acc_seed = 2000;
    send_cmd(7'd20, 7'd4, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (mstart_cnt - m0 == 2) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("abort_pass1_seen", 32'd0, 32'd1);
    bus.abort = 1'b1;
    @(posedge Clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check("abort_mstart", 32'(bus.ma_mstart), 32'd0);
    repeat (12) @(posedge Clk);
    #1;
    check("abort_mstarts", 32'(mstart_cnt - m0), 32'd2);
    check("abort_results", 32'(res_cnt - r0), 32'd1);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_timeout_kept", 32'(bus.timeout_err), 32'd0);
    sb.delete();

    // Asynchronous reset during START
    acc_lat = 1;
    send_cmd(7'd40, 7'd3, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      if (bus.ma_mstart != '0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("rstmid_start_seen", 32'd0, 32'd1);
    #2;
    Rst = 1'b1;
    #1;
    check("rstmid_mstart", 32'(bus.ma_mstart), 32'd0);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rstmid_addr", 32'(bus.ma_addr), 32'd0);
    check("rstmid_res_valid", 32'(bus.res_valid), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("rstmid_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
